avalon_shell_pipe: RTL
======================

Name: avalon_shell_pipe

Overview:
Parametrised successor to the design/Qsys Avalon-MM shell, sitting between the Qsys interconnect and the user design.
- Master path (design -> Qsys): 2-entry registered command buffer, outstanding-read limiter, registered read-return stage. This breaks combinational waitrequest/readdata paths.
- Slave path (Qsys -> design): width adaptation with zero-extension.
- Optional status register intercepts slave address 1.

Parameters:
ADDR_W, 32, master address width
DATA_W, 256, master read/write data width
S_DATA_W, 128, Qsys-side slave data width
DS_DATA_W, 8, design-side slave data width (must be <= S_DATA_W)
MAX_RD, 8, maximum outstanding master reads (1..255)

Ports:
clk  in  1  single clock for all logic
reset  in  1  asynchronous, active-low reset
avm_m0_waitrequest  in  1  Qsys master stall
avm_m0_address  out  ADDR_W  Qsys master address
avm_m0_read  out  1  Qsys master read
avm_m0_write  out  1  Qsys master write
avm_m0_readdatavalid  in  1  Qsys read return valid
avm_m0_readdata  in  DATA_W  Qsys read return data
avm_m0_writedata  out  DATA_W  Qsys write data
avm_design_m0_waitrequest  out  1  stall to design master (registered)
avm_design_m0_address  in  ADDR_W  design address
avm_design_m0_read  in  1  design read
avm_design_m0_write  in  1  design write
avm_design_m0_readdatavalid  out  1  registered read return valid
avm_design_m0_readdata  out  DATA_W  registered read return data
avm_design_m0_writedata  in  DATA_W  design write data
avs_s0_waitrequest  out  1  Qsys slave stall
avs_s0_address  in  1  Qsys slave address
avs_s0_read  in  1  Qsys slave read
avs_s0_write  in  1  Qsys slave write
avs_s0_readdata  out  S_DATA_W  Qsys slave read data
avs_s0_writedata  in  S_DATA_W  Qsys slave write data
avm_design_s0_waitrequest  in  1  design slave stall
avm_design_s0_address  out  1  design slave address
avm_design_s0_read  out  1  design slave read
avm_design_s0_write  out  1  design slave write
avm_design_s0_readdata  in  DS_DATA_W  design slave read data
avm_design_s0_writedata  out  DS_DATA_W  design slave write data
shell_err  out  1  sticky protocol-error flag

Behaviour:
Reset values (reset low):
- avm_design_m0_waitrequest=1; buffer empty; rd_cnt=0.
- avm_m0_read/write=0; avm_design_m0_readdatavalid=0; readdata=0; shell_err=0.
- waitrequest drops in the first clk edge after reset deasserts.
- Reset mid-operation discards buffered commands and in-flight read accounting.

Command accept:
- A command is accepted when (read|write) && !avm_design_m0_waitrequest.
- {address, read, write, writedata} is pushed into the 2-entry FIFO.
- read&write together: accepted as write, shell_err set.
- Registered stall: waitrequest_q <= (next_count == 2). The second entry is the skid slot, so a push in the cycle waitrequest rises is never lost.

Issue to Qsys:
- The head entry is driven onto avm_m0_* when count>0.
- A read head is held (read=0) while rd_cnt==MAX_RD.
- Pop when presented && !avm_m0_waitrequest.
- Command order is strictly preserved; a write behind a blocked read also waits.

Outstanding counter:
- rd_cnt +1 on an accepted read issue; -1 on avm_m0_readdatavalid.
- Both in the same cycle: unchanged.
- readdatavalid with rd_cnt==0: counter holds at 0, shell_err set.
- Counter never exceeds MAX_RD.

Read return:
- avm_design_m0_readdatavalid/readdata are registered copies of the Qsys inputs; fixed latency +1 cycle.
- Data register loads only when valid (holds otherwise).

Empty/full:
- Simultaneous push and pop at count==2: not possible, since waitrequest_q=1.
- At count==1: count stays 1.

Slave path (combinational):
- Design read, write, address and waitrequest pass through.
- avm_design_s0_writedata = avs_s0_writedata[DS_DATA_W-1:0].
- avs_s0_readdata = zero-extended avm_design_s0_readdata; upper bits are always 0.

shell_err is cleared only by reset.

Optional Feature:
AVALON_SHELL_STATUS_EN
- Defined: slave address 1 is intercepted and not forwarded; design s0 read/write are gated to 0 for address 1 and waitrequest is forced 0.
  - Read returns {shell_err, 7'b0, rd_cnt[7:0], buffer count[1:0]} at bits [17:0], zero-extended.
  - Write with writedata[0]=1 clears shell_err; this takes precedence over a same-cycle error set.
- Undefined: both addresses pass through to the design unchanged.

Decomposition:
- Package avalon_shell_pkg: command struct typedef {addr, read, write, wdata} sized from default widths; constant FIFO_DEPTH=2; status-field bit offsets.
- Sub-module avalon_cmd_skid: 2-entry FIFO with registered full/stall output, reusable for future shells.

Test Plan:
- Reset released; design reads addr 0x100 with Qsys waitrequest=0 -> avm_m0_read at 0x100 within 1-2 cycles; readdatavalid with data 0xA5.. returns to design exactly 1 cycle later.
- MAX_RD=8; design issues 10 reads with no returns -> 8 issued; 9th held at avm_m0 with read=0; one readdatavalid -> 9th issues the next cycle.
- Qsys waitrequest held high for 5 cycles during a write burst -> design waitrequest=1 after 2 accepts; no command lost or duplicated; order preserved after release.
- Same-cycle read issue and readdatavalid with rd_cnt=3 -> rd_cnt stays 3.
- readdatavalid with rd_cnt=0 -> shell_err=1 and stays 1; slave readdata upper bits 0 for design data 0x5C -> avs_s0_readdata=0x...005C.
- With AVALON_SHELL_STATUS_EN: read slave addr 1 after the error -> bit17=1; write 1 -> bit17=0; design s0 read/write never asserted.

Source files
------------

// File: rtl/avalon_shell_pkg.sv
// avalon_shell_pkg
//   Shared types and constants for the Avalon-MM shell.
//   - cmd_t        : one buffered master command {addr, read, write, wdata},
//                    sized from the default shell widths (32-bit address,
//                    256-bit data).
//   - FIFO_DEPTH   : depth of the command skid buffer (2).
//   - STAT_*       : bit layout of the optional status word returned on
//                    slave address 1 when AVALON_SHELL_STATUS_EN is defined.
package avalon_shell_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 256;

    localparam int FIFO_DEPTH = 2;

    // Status word: {err, 7'b0, rd_cnt[7:0], count[1:0]} in bits [17:0]
    localparam int STAT_CNT_LSB   = 0;
    localparam int STAT_CNT_W     = 2;
    localparam int STAT_RDCNT_LSB = 2;
    localparam int STAT_RDCNT_W   = 8;
    localparam int STAT_ERR_BIT   = 17;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic                  read;
        logic                  write;
        logic [DEF_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/avalon_cmd_skid.sv
// avalon_cmd_skid
//   Two-entry command FIFO whose stall output is registered. The stall rises
//   when the FIFO will hold two entries after this edge; the second entry is
//   the skid slot that absorbs a push made in the same cycle the stall rises.
//   Ports:
//     clk, reset     : clock, asynchronous active-low reset
//     push_i         : write push_data_i (ignored while full_o)
//     push_data_i    : entry to store
//     pop_i          : drop the head entry (ignored while empty)
//     head_o         : oldest entry (valid when count_o != 0)
//     count_o        : number of stored entries (0..2)
//     full_o         : registered stall, 1 in reset and when two entries held
module avalon_cmd_skid
    import avalon_shell_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             full_q;
    logic             push_ok, pop_ok;

    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & (count_q != 2'd0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = ~wr_ptr_q;
        if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            full_q   <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == 2'(FIFO_DEPTH));
        end
    end

    // Payload storage carries no reset; count_q qualifies it.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;

endmodule

// File: rtl/avalon_shell_pipe.sv
// avalon_shell_pipe
//   Avalon-MM shell between the Qsys interconnect and the user design.
//   Master path (design -> Qsys): 2-entry registered command buffer,
//   outstanding-read limiter (MAX_RD), registered read-return stage.
//   Slave path (Qsys -> design): combinational pass-through with data width
//   adaptation (truncate write data, zero-extend read data).
//   Optional macro AVALON_SHELL_STATUS_EN: slave address 1 returns a status
//   word {shell_err, 7'b0, rd_cnt, buffer count} and a write with bit 0 set
//   clears shell_err; that address is then never forwarded to the design.
//   Ports:
//     clk, reset               : clock, asynchronous active-low reset
//     avm_m0_*                 : master towards Qsys
//     avm_design_m0_*          : master from the design
//     avs_s0_*                 : slave from Qsys
//     avm_design_s0_*          : slave towards the design
//     shell_err                : sticky protocol error (read&write together,
//                                or a read return with nothing outstanding)
//   Handshake: a command transfers on an edge where read|write is high and
//   waitrequest is low; the requester holds its command until then.
module avalon_shell_pipe
    import avalon_shell_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int S_DATA_W  = 128,
    parameter int DS_DATA_W = 8,
    parameter int MAX_RD    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 avm_m0_waitrequest,
    output logic [ADDR_W-1:0]    avm_m0_address,
    output logic                 avm_m0_read,
    output logic                 avm_m0_write,
    input  logic                 avm_m0_readdatavalid,
    input  logic [DATA_W-1:0]    avm_m0_readdata,
    output logic [DATA_W-1:0]    avm_m0_writedata,
    output logic                 avm_design_m0_waitrequest,
    input  logic [ADDR_W-1:0]    avm_design_m0_address,
    input  logic                 avm_design_m0_read,
    input  logic                 avm_design_m0_write,
    output logic                 avm_design_m0_readdatavalid,
    output logic [DATA_W-1:0]    avm_design_m0_readdata,
    input  logic [DATA_W-1:0]    avm_design_m0_writedata,
    output logic                 avs_s0_waitrequest,
    input  logic                 avs_s0_address,
    input  logic                 avs_s0_read,
    input  logic                 avs_s0_write,
    output logic [S_DATA_W-1:0]  avs_s0_readdata,
    input  logic [S_DATA_W-1:0]  avs_s0_writedata,
    input  logic                 avm_design_s0_waitrequest,
    output logic                 avm_design_s0_address,
    output logic                 avm_design_s0_read,
    output logic                 avm_design_s0_write,
    input  logic [DS_DATA_W-1:0] avm_design_s0_readdata,
    output logic [DS_DATA_W-1:0] avm_design_s0_writedata,
    output logic                 shell_err
);

    localparam int CMD_W = ADDR_W + 2 + DATA_W;

    logic [CMD_W-1:0]  push_data, head;
    logic [1:0]        count;
    logic              full, push, pop;
    logic              head_valid, head_rd, head_wr, rd_blocked;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic              rd_inc, err_set;
    logic [7:0]        rd_cnt_q, rd_cnt_d;
    logic              err_q, err_d;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [S_DATA_W-1:0] ds_ext;

    // ---------------- master path: command buffer ----------------
    assign push = (avm_design_m0_read | avm_design_m0_write) & ~full;
    // read and write together is stored as a plain write
    assign push_data = {avm_design_m0_address,
                        avm_design_m0_read & ~avm_design_m0_write,
                        avm_design_m0_write,
                        avm_design_m0_writedata};

    avalon_cmd_skid #(.WIDTH(CMD_W)) u_skid (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .full_o      (full)
    );

    assign {head_addr, head_rd, head_wr, head_wdata} = head;
    assign head_valid = (count != 2'd0);
    // a read at the head blocks everything behind it while the limit is hit
    assign rd_blocked = head_rd & (rd_cnt_q == 8'(MAX_RD));

    assign avm_m0_read      = head_valid & head_rd & ~rd_blocked;
    assign avm_m0_write     = head_valid & head_wr;
    assign avm_m0_address   = head_addr;
    assign avm_m0_writedata = head_wdata;
    assign pop              = (avm_m0_read | avm_m0_write) & ~avm_m0_waitrequest;
    assign avm_design_m0_waitrequest = full;

    // ---------------- outstanding reads and error flag ----------------
    assign rd_inc  = avm_m0_read & ~avm_m0_waitrequest;
    assign err_set = (push & avm_design_m0_read & avm_design_m0_write)
                   | (avm_m0_readdatavalid & (rd_cnt_q == 8'd0));

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (rd_inc && !avm_m0_readdatavalid)
            rd_cnt_d = rd_cnt_q + 8'd1;
        else if (!rd_inc && avm_m0_readdatavalid && (rd_cnt_q != 8'd0))
            rd_cnt_d = rd_cnt_q - 8'd1;
    end

`ifdef AVALON_SHELL_STATUS_EN
    logic                stat_hit, stat_clr;
    logic [S_DATA_W-1:0] stat_word;

    assign stat_hit = avs_s0_address;
    assign stat_clr = stat_hit & avs_s0_write & avs_s0_writedata[0];

    always_comb begin
        stat_word = '0;
        stat_word[STAT_ERR_BIT]                     = err_q;
        stat_word[STAT_RDCNT_LSB +: STAT_RDCNT_W]   = rd_cnt_q;
        stat_word[STAT_CNT_LSB +: STAT_CNT_W]       = count;
    end
`endif

    always_comb begin
        err_d = err_q | err_set;
`ifdef AVALON_SHELL_STATUS_EN
        // software clear wins over an error raised in the same cycle
        if (stat_clr) err_d = 1'b0;
`endif
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_cnt_q <= 8'd0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            err_q    <= err_d;
            rvalid_q <= avm_m0_readdatavalid;
            if (avm_m0_readdatavalid) rdata_q <= avm_m0_readdata;
        end
    end

    assign avm_design_m0_readdatavalid = rvalid_q;
    assign avm_design_m0_readdata      = rdata_q;
    assign shell_err                   = err_q;

    // ---------------- slave path ----------------
    always_comb begin
        ds_ext = '0;
        ds_ext[DS_DATA_W-1:0] = avm_design_s0_readdata;
    end

    assign avm_design_s0_address   = avs_s0_address;
    assign avm_design_s0_writedata = avs_s0_writedata[DS_DATA_W-1:0];

`ifdef AVALON_SHELL_STATUS_EN
    assign avm_design_s0_read  = avs_s0_read & ~stat_hit;
    assign avm_design_s0_write = avs_s0_write & ~stat_hit;
    assign avs_s0_waitrequest  = stat_hit ? 1'b0 : avm_design_s0_waitrequest;
    assign avs_s0_readdata     = stat_hit ? stat_word : ds_ext;
`else
    assign avm_design_s0_read  = avs_s0_read;
    assign avm_design_s0_write = avs_s0_write;
    assign avs_s0_waitrequest  = avm_design_s0_waitrequest;
    assign avs_s0_readdata     = ds_ext;
`endif

    // upper slave write-data bits have no destination on the design side
    if (S_DATA_W > DS_DATA_W) begin : g_unused
        logic unused_wdata;
        assign unused_wdata = ^avs_s0_writedata[S_DATA_W-1:DS_DATA_W];
    end

endmodule
